safecrack_access_arbiter: RTL

- Shares the single safecrack lock digit-entry port between two requesters: front-panel keypad (req 0) and remote console (req 1).
- Grants one entry session at a time, using round-robin when both request.
- While a session is open, forwards exactly N_DIGITS digits from the granted requester to the lock, then waits for the lock's verdict and returns it to that requester.
- Enforces an inactivity timeout and aborts partial sessions cleanly. Sits between the input front-ends and the lock FSM.

---
 rtl/safecrack_access_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/safecrack_access_arbiter.sv
// Shares the lock's digit-entry port between the keypad (req 0) and the remote console (req 1).
// One session at a time, round-robin on ties, with an inactivity timeout.
module safecrack_access_arbiter #(
  parameter int N_DIGITS       = 3,
  parameter int SESSION_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] digit_valid,
  input  logic [3:0] digit,
  input  logic       lock_busy,
  input  logic       lock_result_valid,
  input  logic       lock_result_ok,
  output logic [1:0] gnt,
  output logic       lock_digit_valid,
  output logic [1:0] lock_digit,
  output logic       lock_abort,
  output logic [1:0] done,
  output logic       result_ok,
  output logic       timeout
);

  localparam int TW = (SESSION_CYCLES > 1) ? $clog2(SESSION_CYCLES) : 1;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(SESSION_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_DIGITS - 1);

  // IDLE: arbitrate | GRANT: forward digits | WAIT_RESULT: await verdict | RELEASE: drop grant
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RESULT, RELEASE} state_t;

  state_t        state_q;
  logic [1:0]    gnt_q;
  logic          gidx_q;
  logic          last_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] timer_q;
  logic          ldv_q;
  logic [1:0]    ld_q;
  logic          abort_q;
  logic [1:0]    done_q;
  logic          result_ok_q;
  logic          timeout_q;

  logic       pick_d;
  logic       own_req;
  logic       own_strobe;
  logic [1:0] own_digit;
  logic       tmr_exp;

  assign pick_d     = (req == 2'b11) ? ~last_q : req[1];
  assign own_req    = req[gidx_q];
  assign own_strobe = digit_valid[gidx_q];
  assign own_digit  = gidx_q ? digit[3:2] : digit[1:0];
  assign tmr_exp    = (timer_q == T_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      gidx_q      <= 1'b0;
      last_q      <= 1'b1;
      count_q     <= '0;
      timer_q     <= '0;
      ldv_q       <= 1'b0;
      ld_q        <= 2'b00;
      abort_q     <= 1'b0;
      done_q      <= 2'b00;
      result_ok_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      ldv_q       <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 2'b00;
      result_ok_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!lock_busy && (req != 2'b00)) begin
            gidx_q  <= pick_d;
            gnt_q   <= pick_d ? 2'b10 : 2'b01;
            count_q <= '0;
            timer_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request outranks a same-cycle strobe; a strobe outranks expiry.
          if (!own_req) begin
            abort_q <= 1'b1;
            state_q <= RELEASE;
          end else if (own_strobe) begin
            ldv_q   <= 1'b1;
            ld_q    <= own_digit;
            timer_q <= '0;
            count_q <= count_q + 1'b1;
            if (count_q == C_LAST) state_q <= WAIT_RESULT;
          end else if (tmr_exp) begin
            abort_q   <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= RELEASE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_RESULT: begin
          if (lock_result_valid) begin
            done_q      <= gidx_q ? 2'b10 : 2'b01;
            result_ok_q <= lock_result_ok;
            state_q     <= RELEASE;
          end else if (tmr_exp) begin
            done_q    <= gidx_q ? 2'b10 : 2'b01;
            timeout_q <= 1'b1;
            state_q   <= RELEASE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RELEASE: begin
          gnt_q   <= 2'b00;
          last_q  <= gidx_q;
          count_q <= '0;
          timer_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt              = gnt_q;
  assign lock_digit_valid = ldv_q;
  assign lock_digit       = ld_q;
  assign lock_abort       = abort_q;
  assign done             = done_q;
  assign result_ok        = result_ok_q;
  assign timeout          = timeout_q;

endmodule
